mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide controller that sits beside the E-stage ALU in the pipelined MIPS core.
- Accepts one MDU operation per start, latches its operands, counts the fixed latency and commits the result into the HI/LO pair.
- Drives busy so the hazard unit can stall later MDU instructions in D.
- Honours an exception/interrupt cancel so a flushed E-stage instruction never alters HI/LO.

---
 rtl/mdu_ctrl.sv | 142 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO pair, with a latency counter and busy.
// Define MDU_MADD_EN to add the MADD/MADDU multiply-accumulate opcodes.
module mdu_ctrl #(
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  MDUOp,
   input  logic        start,
   input  logic        req,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;

   localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
   localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

   state_t      state;
   logic [3:0]  cnt;
   logic [3:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [31:0] hi_q, lo_q;
   logic        busy_q;

   logic [63:0] prod_s, prod_u;
   logic        div_signed;
   logic [31:0] num, den, q_m, r_m, div_q, div_r;
   logic        wr_en;
   logic [31:0] hi_nxt, lo_nxt;

   function automatic logic is_multi(input logic [3:0] op);
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_multi = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU:                  is_multi = 1'b1;
`endif
         default:                            is_multi = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] op_lat(input logic [3:0] op);
      op_lat = (op == OP_DIV || op == OP_DIVU) ? DIV_CNT : MUL_CNT;
   endfunction

   // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
   always_comb begin
      prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      prod_u     = {32'b0, a_q} * {32'b0, b_q};
      div_signed = (op_q == OP_DIV);
      num        = (div_signed && a_q[31]) ? -a_q : a_q;
      den        = (div_signed && b_q[31]) ? -b_q : b_q;
      q_m        = (den == 32'd0) ? 32'd0 : num / den;
      r_m        = (den == 32'd0) ? 32'd0 : num % den;
      div_q      = (div_signed && (a_q[31] ^ b_q[31])) ? -q_m : q_m;
      div_r      = (div_signed && a_q[31]) ? -r_m : r_m;

      wr_en  = 1'b0;
      hi_nxt = hi_q;
      lo_nxt = lo_q;
      case (op_q)
         OP_MULT:  begin wr_en = 1'b1; {hi_nxt, lo_nxt} = prod_s; end
         OP_MULTU: begin wr_en = 1'b1; {hi_nxt, lo_nxt} = prod_u; end
         OP_DIV, OP_DIVU: begin
            wr_en  = (b_q != 32'd0);
            hi_nxt = div_r;
            lo_nxt = div_q;
         end
`ifdef MDU_MADD_EN
         OP_MADD:  begin wr_en = 1'b1; {hi_nxt, lo_nxt} = {hi_q, lo_q} + prod_s; end
         OP_MADDU: begin wr_en = 1'b1; {hi_nxt, lo_nxt} = {hi_q, lo_q} + prod_u; end
`endif
         default:  wr_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         op_q   <= 4'd0;
         a_q    <= 32'd0;
         b_q    <= 32'd0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!req) begin
                  if (start && is_multi(MDUOp)) begin
                     state  <= RUN;
                     op_q   <= MDUOp;
                     a_q    <= A;
                     b_q    <= B;
                     cnt    <= op_lat(MDUOp);
                     busy_q <= 1'b1;
                  end else if (MDUOp == OP_MTHI) begin
                     hi_q <= A;
                  end else if (MDUOp == OP_MTLO) begin
                     lo_q <= A;
                  end
               end
            end
            RUN: begin
               // The instruction has left E, so req and a stray start cannot disturb it here.
               if (cnt == 4'd1) begin
                  if (wr_en) begin
                     hi_q <= hi_nxt;
                     lo_q <= lo_nxt;
                  end
                  state  <= IDLE;
                  cnt    <= 4'd0;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl: latency, results, cancel, reset-abort and MADD option.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A, B;
   logic [3:0]  MDUOp;
   logic        start, req;
   logic        busy;
   logic [31:0] HI, LO;

   int errors = 0;
   int checks = 0;

   mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp),
      .start(start), .req(req), .busy(busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch a multi-cycle op and count busy cycles; optionally inject req or a stray start mid-run.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int req_at, input int start_at, output int cyc);
      MDUOp = op; A = a; B = b; start = 1'b1; req = 1'b0;
      step();
      start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
      cyc = 0;
      while (busy && cyc < 40) begin
         cyc++;
         if (cyc == req_at) req = 1'b1;
         if (cyc == start_at) begin
            start = 1'b1; MDUOp = 4'd2; A = 32'd9; B = 32'd9;
            $display("note: protocol violation, start asserted while busy at cycle %0d", cyc);
         end
         step();
         req = 1'b0; start = 1'b0; MDUOp = 4'd0;
      end
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic r);
      MDUOp = op; A = a; req = r; start = 1'b0;
      step();
      MDUOp = 4'd0; req = 1'b0; A = 32'd0;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; req = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
      step(); step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", HI); end
      checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", LO); end
      reset = 1'b1;
      step();
   endtask

   task automatic test_reset_mid_run();
      MDUOp = 4'd1; A = 32'd3; B = 32'd4; start = 1'b1;
      step();
      start = 1'b0; MDUOp = 4'd0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_run_busy_start got=%0b exp=1", busy); end
      step(); step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy got=%0b exp=0", busy); end
      repeat (6) step();
      checks++; if ({HI, LO} !== 64'd0) begin errors++; $display("FAIL rst_run_hilo got=%h exp=0", {HI, LO}); end
   endtask

   task automatic test_mult();
      int cyc;
      run_op(4'd1, 32'hFFFFFFFE, 32'd3, -1, -1, cyc);
      checks++; if (cyc != 5) begin errors++; $display("FAIL mult_lat got=%0d exp=5", cyc); end
      checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
      checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", LO); end
      run_op(4'd2, 32'hFFFFFFFE, 32'd3, -1, -1, cyc);
      checks++; if (cyc != 5) begin errors++; $display("FAIL multu_lat got=%0d exp=5", cyc); end
      checks++; if (HI !== 32'h00000002) begin errors++; $display("FAIL multu_hi got=%h exp=00000002", HI); end
      checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo got=%h exp=fffffffa", LO); end
   endtask

   task automatic test_div();
      int cyc;
      run_op(4'd3, 32'hFFFFFFF9, 32'd2, -1, -1, cyc);
      checks++; if (cyc != 10) begin errors++; $display("FAIL div_lat got=%0d exp=10", cyc); end
      checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
      checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
      run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, -1, -1, cyc);
      checks++; if (LO !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got=%h exp=80000000", LO); end
      checks++; if (HI !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi got=%h exp=00000000", HI); end
      run_op(4'd4, 32'hFFFFFFF9, 32'd2, -1, -1, cyc);
      checks++; if (LO !== 32'h7FFFFFFC) begin errors++; $display("FAIL divu_lo got=%h exp=7ffffffc", LO); end
      checks++; if (HI !== 32'h00000001) begin errors++; $display("FAIL divu_hi got=%h exp=00000001", HI); end
      mt(4'd5, 32'h11, 1'b0);
      mt(4'd6, 32'h22, 1'b0);
      run_op(4'd4, 32'd7, 32'd0, -1, -1, cyc);
      checks++; if (cyc != 10) begin errors++; $display("FAIL div0_lat got=%0d exp=10", cyc); end
      checks++; if (HI !== 32'h11) begin errors++; $display("FAIL div0_hi got=%h exp=00000011", HI); end
      checks++; if (LO !== 32'h22) begin errors++; $display("FAIL div0_lo got=%h exp=00000022", LO); end
   endtask

   task automatic test_req();
      MDUOp = 4'd1; A = 32'd5; B = 32'd5; start = 1'b1; req = 1'b1;
      step();
      start = 1'b0; req = 1'b0; MDUOp = 4'd0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_start_busy got=%0b exp=0", busy); end
      repeat (6) step();
      checks++; if ({HI, LO} !== {32'h11, 32'h22}) begin errors++; $display("FAIL req_start_hilo got=%h exp=%h", {HI, LO}, {32'h11, 32'h22}); end
      MDUOp = 4'd0; A = 32'd5; B = 32'd5; start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nop_start_busy got=%0b exp=0", busy); end
      mt(4'd5, 32'hABCD, 1'b1);
      checks++; if (HI !== 32'h11) begin errors++; $display("FAIL mthi_req got=%h exp=00000011", HI); end
      mt(4'd5, 32'hABCD, 1'b0);
      checks++; if (HI !== 32'hABCD) begin errors++; $display("FAIL mthi got=%h exp=0000abcd", HI); end
      mt(4'd6, 32'h1234, 1'b0);
      checks++; if (LO !== 32'h1234) begin errors++; $display("FAIL mtlo got=%h exp=00001234", LO); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      run_op(4'd3, 32'd100, 32'd7, 3, -1, cyc);
      checks++; if (cyc != 10) begin errors++; $display("FAIL req_run_lat got=%0d exp=10", cyc); end
      checks++; if (LO !== 32'd14) begin errors++; $display("FAIL req_run_lo got=%0d exp=14", LO); end
      checks++; if (HI !== 32'd2) begin errors++; $display("FAIL req_run_hi got=%0d exp=2", HI); end
      mt(4'd5, 32'd0, 1'b0);
      mt(4'd6, 32'd0, 1'b0);
      run_op(4'd3, 32'd100, 32'd7, -1, 4, cyc);
      checks++; if (cyc != 10) begin errors++; $display("FAIL busy_start_lat got=%0d exp=10", cyc); end
      checks++; if (LO !== 32'd14) begin errors++; $display("FAIL busy_start_lo got=%0d exp=14", LO); end
      checks++; if (HI !== 32'd2) begin errors++; $display("FAIL busy_start_hi got=%0d exp=2", HI); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got=%0b exp=0", busy); end
   endtask

   task automatic test_madd();
      int cyc;
      mt(4'd5, 32'd0, 1'b0);
      mt(4'd6, 32'hFFFFFFFF, 1'b0);
      run_op(4'd8, 32'd1, 32'd1, -1, -1, cyc);
`ifdef MDU_MADD_EN
      checks++; if (cyc != 5) begin errors++; $display("FAIL maddu_lat got=%0d exp=5", cyc); end
      checks++; if (HI !== 32'd1) begin errors++; $display("FAIL maddu_hi got=%h exp=00000001", HI); end
      checks++; if (LO !== 32'd0) begin errors++; $display("FAIL maddu_lo got=%h exp=00000000", LO); end
      run_op(4'd7, 32'hFFFFFFFF, 32'd1, -1, -1, cyc);
      checks++; if ({HI, LO} !== 64'hFFFFFFFF) begin errors++; $display("FAIL madd_hilo got=%h exp=00000000ffffffff", {HI, LO}); end
`else
      checks++; if (cyc != 0) begin errors++; $display("FAIL maddu_off_busy got=%0d exp=0", cyc); end
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL maddu_off_hi got=%h exp=00000000", HI); end
      checks++; if (LO !== 32'hFFFFFFFF) begin errors++; $display("FAIL maddu_off_lo got=%h exp=ffffffff", LO); end
`endif
   endtask

   initial begin
      test_reset();
      test_reset_mid_run();
      test_mult();
      test_div();
      test_req();
      test_back_to_back();
      test_madd();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
